// File: rtl/xy_pkg.sv
// Shared constants and types for the x/y capture FIFO.
package xy_pkg;

    localparam int unsigned DEF_W     = 4;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DROP_MAX  = 255;

    typedef struct packed {
        logic [DEF_W-1:0] x;
        logic [DEF_W-1:0] y;
    } xy_pair_t;

endpackage

// File: rtl/xy_fifo.sv
// Power-of-two FIFO: storage, pointers and occupancy; head reads as zero when empty.
module xy_fifo
    import xy_pkg::*;
#(
    parameter int unsigned DW    = 2 * DEF_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DW-1:0]            head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;
    logic          full, empty, do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wptr_q] <= wdata;
    end

    assign level = level_q;
    assign head  = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/xy_capture_fifo.sv
// Captures changed {x,y} counter pairs into a FIFO, tracking drops and x wrap events.
module xy_capture_fifo
    import xy_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr,
    input  logic [W-1:0]             x,
    input  logic [W-1:0]             y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [7:0]               drop_cnt,
    output logic [7:0]               x_wraps
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [2*W-1:0] pair, last_q;
    logic           last_vld_q;
    logic [W-1:0]   prev_x_q;
    logic           prev_x_vld_q;
    logic           ovf_q;
    logic [7:0]     drop_q, wraps_q;
    logic           full, pop, cap_req, push, drop, wrap;

    assign pair      = {x, y};
    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign cap_req   = en && (!last_vld_q || (pair != last_q));
    assign push      = cap_req && (!full || pop);
    assign drop      = cap_req && full && !pop;
    assign wrap      = en && prev_x_vld_q && (prev_x_q == '1) && (x == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q       <= '0;
            last_vld_q   <= 1'b0;
            prev_x_q     <= '0;
            prev_x_vld_q <= 1'b0;
            ovf_q        <= 1'b0;
            drop_q       <= '0;
            wraps_q      <= '0;
        end else if (clr) begin
            last_vld_q   <= 1'b0;
            prev_x_vld_q <= 1'b0;
            ovf_q        <= 1'b0;
            drop_q       <= '0;
            wraps_q      <= '0;
        end else begin
            if (push) begin
                last_q     <= pair;
                last_vld_q <= 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'(DROP_MAX)) drop_q <= drop_q + 1'b1;
            end
            // Wrap detection only looks at samples taken with en high.
            if (en) begin
                prev_x_q     <= x;
                prev_x_vld_q <= 1'b1;
                if (wrap) wraps_q <= wraps_q + 1'b1;
            end
        end
    end

    xy_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (pair),
        .level (level),
        .head  (out_data)
    );

    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;
    assign x_wraps  = wraps_q;

endmodule

// File: tb/tb_xy_capture_fifo.sv
// Self-checking bench for xy_capture_fifo against a queue-based reference model.
module tb_xy_capture_fifo;
    import xy_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           en = 1'b0;
    logic           clr = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic           out_valid;
    logic [2*W-1:0] out_data;
    logic [LW-1:0]  level;
    logic           ovf;
    logic [7:0]     drop_cnt;
    logic [7:0]     x_wraps;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2*W-1:0] mq[$];
    logic [2*W-1:0] m_last;
    bit             m_lastv;
    logic [W-1:0]   m_prevx;
    bit             m_prevxv;
    bit             m_ovf;
    int             m_drop;
    int             m_wraps;

    always #5 clk = ~clk;

    xy_capture_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .x_wraps   (x_wraps)
    );

    function automatic void model_reset();
        mq.delete();
        m_lastv  = 0;
        m_prevxv = 0;
        m_ovf    = 0;
        m_drop   = 0;
        m_wraps  = 0;
    endfunction

    function automatic void model_step();
        logic [2*W-1:0] p;
        bit             popped, req, was_full;
        p = {x, y};
        if (clr) begin
            model_reset();
            return;
        end
        was_full = (mq.size() == DEPTH);
        popped   = (mq.size() != 0) && out_ready;
        req      = en && (!m_lastv || p != m_last);
        if (popped) void'(mq.pop_front());
        if (req) begin
            if (!was_full || popped) begin
                mq.push_back(p);
                m_last  = p;
                m_lastv = 1;
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (en) begin
            if (m_prevxv && m_prevx == 4'hF && x == 4'h0) m_wraps = (m_wraps + 1) % 256;
            m_prevx  = x;
            m_prevxv = 1;
        end
    endfunction

    function automatic logic [2*W-1:0] m_head();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        en  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #3;
        checks++;
        if (level !== '0 || out_valid !== 1'b0 || out_data !== '0 || ovf !== 1'b0
            || drop_cnt !== 8'd0 || x_wraps !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: level=%0d valid=%0b data=%0h ovf=%0b drop=%0d wraps=%0d, expected all zero",
                     level, out_valid, out_data, ovf, drop_cnt, x_wraps);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_hold();
        en = 1'b1; x = 4'h1; y = 4'h1; out_ready = 1'b0;
        repeat (5) tick();
        en = 1'b0;
        checks++;
        if (level !== LW'(1) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_level: level=%0d valid=%0b, expected 1/1", level, out_valid);
        end
        checks++;
        if (out_data !== 8'h11) begin
            errors++;
            $display("FAIL hold_data: got %0h expected 11", out_data);
        end
    endtask

    task automatic test_overflow();
        logic [2*W-1:0] exp;
        do_clr();
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x = 4'(i); y = 4'(i + 3);
            tick();
        end
        en = 1'b0;
        checks++;
        if (level !== LW'(8) || ovf !== 1'b1 || drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overflow_state: level=%0d ovf=%0b drop=%0d, expected 8/1/2",
                     level, ovf, drop_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = {4'(i), 4'(i + 3)};
            checks++;
            if (out_data !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL overflow_pop%0d: got %0h valid=%0b expected %0h", i, out_data,
                         out_valid, exp);
            end
            tick();
        end
        checks++;
        if (level !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL overflow_drained: level=%0d valid=%0b data=%0h, expected 0",
                     level, out_valid, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_stream();
        do_clr();
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = 4'(i); y = 4'h5;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x = 4'(i); y = 4'hA;
            tick();
            checks++;
            if (level !== LW'(8) || drop_cnt !== 8'd0 || ovf !== 1'b0 || out_data !== m_head()) begin
                errors++;
                $display("FAIL full_stream%0d: level=%0d drop=%0d ovf=%0b data=%0h, expected 8/0/0/%0h",
                         i, level, drop_cnt, ovf, out_data, m_head());
            end
        end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [W-1:0] sweep [4];
        sweep[0] = 4'd14; sweep[1] = 4'd15; sweep[2] = 4'd0; sweep[3] = 4'd1;
        out_ready = 1'b1;
        do_clr();
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; x = sweep[i]; y = 4'h0;
            tick();
        end
        checks++;
        if (x_wraps !== 8'd1) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 1", x_wraps);
        end
        do_clr();
        for (int i = 0; i < 4; i++) begin
            en = (i != 1); x = sweep[i]; y = 4'h0;
            tick();
        end
        checks++;
        if (x_wraps !== 8'd0) begin
            errors++;
            $display("FAIL wrap_gated: got %0d expected 0", x_wraps);
        end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_drop_sat();
        do_clr();
        out_ready = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            {x, y} = 8'(k);
            tick();
        end
        for (int j = 0; j < 300; j++) begin
            {x, y} = 8'(8 + (j % 200));
            tick();
        end
        checks++;
        if (drop_cnt !== 8'd255 || ovf !== 1'b1 || level !== LW'(8)) begin
            errors++;
            $display("FAIL drop_saturate: drop=%0d ovf=%0b level=%0d, expected 255/1/8",
                     drop_cnt, ovf, level);
        end
        clr = 1'b1; {x, y} = 8'hE7;
        tick();
        clr = 1'b0;
        checks++;
        if (level !== '0 || ovf !== 1'b0 || drop_cnt !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: level=%0d ovf=%0b drop=%0d valid=%0b, expected zeros",
                     level, ovf, drop_cnt, out_valid);
        end
        tick();
        checks++;
        if (level !== LW'(1) || out_data !== 8'hE7) begin
            errors++;
            $display("FAIL clr_forgets_last: level=%0d data=%0h, expected 1/e7", level, out_data);
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_clr();
        out_ready = 1'b0;
        en = 1'b1; {x, y} = 8'h3C;
        tick();
        out_ready = 1'b1; {x, y} = 8'hC3;
        tick();
        checks++;
        if (level !== LW'(1) || out_valid !== 1'b1 || out_data !== 8'hC3) begin
            errors++;
            $display("FAIL level1_pushpop: level=%0d valid=%0b data=%0h, expected 1/1/c3",
                     level, out_valid, out_data);
        end
        en = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        checks++;
        if (out_data !== 8'hC3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_stable: data=%0h valid=%0b, expected c3/1", out_data, out_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] xs [5];
        xs[0] = 4'd14; xs[1] = 4'd15; xs[2] = 4'd0; xs[3] = 4'd1; xs[4] = 4'd2;
        do_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; x = xs[i]; y = 4'h0;
            tick();
        end
        en = 1'b0;
        checks++;
        if (level !== LW'(5) || x_wraps !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset: level=%0d wraps=%0d, expected 5/1", level, x_wraps);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (level !== '0 || out_valid !== 1'b0 || out_data !== '0 || ovf !== 1'b0
            || drop_cnt !== 8'd0 || x_wraps !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: level=%0d valid=%0b data=%0h ovf=%0b drop=%0d wraps=%0d, expected zeros",
                     level, out_valid, out_data, ovf, drop_cnt, x_wraps);
        end
        #2;
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL post_reset: valid=%0b level=%0d, expected 0/0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        xy_pair_t hp;
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 59) == 0);
            out_ready = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) begin
                x = 4'($urandom_range(0, 15));
                y = 4'($urandom_range(0, 3));
            end
            tick();
            hp = xy_pair_t'(m_head());
            checks++;
            if (level !== LW'(mq.size()) || out_valid !== (mq.size() != 0) || out_data !== hp
                || ovf !== m_ovf || drop_cnt !== 8'(m_drop) || x_wraps !== 8'(m_wraps)) begin
                errors++;
                $display("FAIL random%0d: level=%0d/%0d valid=%0b data=%0h/%0h ovf=%0b/%0b drop=%0d/%0d wraps=%0d/%0d",
                         c, level, mq.size(), out_valid, out_data, hp, ovf, m_ovf,
                         drop_cnt, m_drop, x_wraps, m_wraps);
            end
        end
        clr = 1'b0; en = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_overflow();
        test_full_stream();
        test_wrap();
        test_drop_sat();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
